// File: rtl/ps2_scancode_decoder_pkg.sv
// Shared definitions for the PS/2 set-2 scan-code decoder:
// FSM state encoding, prefix bytes, shift codes and the discard-code list.
package ps2_pkg;

   // Byte-handling FSM: wait for a byte, pop it, then classify it
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_POP  = 2'd1,
      ST_PROC = 2'd2
   } ps2_state_e;

   // Prefix bytes of the set-2 protocol
   localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
   localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;

   // Left and right shift make codes
   localparam logic [7:0] PS2_LSHIFT = 8'h12;
   localparam logic [7:0] PS2_RSHIFT = 8'h59;

   // Distance between lower- and upper-case ASCII letters
   localparam logic [7:0] ASCII_CASE_DELTA = 8'h20;

   // Keyboard status / response bytes that never describe a key
   function automatic logic is_discard(input logic [7:0] code);
      logic hit;
      case (code)
         8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: hit = 1'b1;
         default:                                  hit = 1'b0;
      endcase
      return hit;
   endfunction

   // Either shift key
   function automatic logic is_shift(input logic [7:0] code);
      logic hit;
      case (code)
         PS2_LSHIFT, PS2_RSHIFT: hit = 1'b1;
         default:                hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/ps2_scancode_ascii.sv
// Combinational set-2 scan code to ASCII table.
// Covers a-z, 0-9, space and enter; anything else, and every extended
// (E0-prefixed) code, maps to 0x00. With shift asserted letters become
// upper case; digits, space and enter are unaffected.
module ps2_scancode_ascii
   import ps2_pkg::*;
(
   input  logic [7:0] code,
   input  logic       ext,
   input  logic       shift,
   output logic [7:0] ascii
);

   logic [7:0] base_s;
   logic       letter_s;

   // Table lookup of the unshifted character and whether it is a letter
   always_comb begin
      base_s   = 8'h00;
      letter_s = 1'b0;
      case (code)
         8'h1C: begin base_s = 8'h61; letter_s = 1'b1; end // a
         8'h32: begin base_s = 8'h62; letter_s = 1'b1; end // b
         8'h21: begin base_s = 8'h63; letter_s = 1'b1; end // c
         8'h23: begin base_s = 8'h64; letter_s = 1'b1; end // d
         8'h24: begin base_s = 8'h65; letter_s = 1'b1; end // e
         8'h2B: begin base_s = 8'h66; letter_s = 1'b1; end // f
         8'h34: begin base_s = 8'h67; letter_s = 1'b1; end // g
         8'h33: begin base_s = 8'h68; letter_s = 1'b1; end // h
         8'h43: begin base_s = 8'h69; letter_s = 1'b1; end // i
         8'h3B: begin base_s = 8'h6A; letter_s = 1'b1; end // j
         8'h42: begin base_s = 8'h6B; letter_s = 1'b1; end // k
         8'h4B: begin base_s = 8'h6C; letter_s = 1'b1; end // l
         8'h3A: begin base_s = 8'h6D; letter_s = 1'b1; end // m
         8'h31: begin base_s = 8'h6E; letter_s = 1'b1; end // n
         8'h44: begin base_s = 8'h6F; letter_s = 1'b1; end // o
         8'h4D: begin base_s = 8'h70; letter_s = 1'b1; end // p
         8'h15: begin base_s = 8'h71; letter_s = 1'b1; end // q
         8'h2D: begin base_s = 8'h72; letter_s = 1'b1; end // r
         8'h1B: begin base_s = 8'h73; letter_s = 1'b1; end // s
         8'h2C: begin base_s = 8'h74; letter_s = 1'b1; end // t
         8'h3C: begin base_s = 8'h75; letter_s = 1'b1; end // u
         8'h2A: begin base_s = 8'h76; letter_s = 1'b1; end // v
         8'h1D: begin base_s = 8'h77; letter_s = 1'b1; end // w
         8'h22: begin base_s = 8'h78; letter_s = 1'b1; end // x
         8'h35: begin base_s = 8'h79; letter_s = 1'b1; end // y
         8'h1A: begin base_s = 8'h7A; letter_s = 1'b1; end // z
         8'h45: base_s = 8'h30; // 0
         8'h16: base_s = 8'h31; // 1
         8'h1E: base_s = 8'h32; // 2
         8'h26: base_s = 8'h33; // 3
         8'h25: base_s = 8'h34; // 4
         8'h2E: base_s = 8'h35; // 5
         8'h36: base_s = 8'h36; // 6
         8'h3D: base_s = 8'h37; // 7
         8'h3E: base_s = 8'h38; // 8
         8'h46: base_s = 8'h39; // 9
         8'h29: base_s = 8'h20; // space
         8'h5A: base_s = 8'h0D; // enter
         default: begin
            base_s   = 8'h00;
            letter_s = 1'b0;
         end
      endcase
   end

   // Extended codes share byte values with ordinary keys, so they never map
   always_comb begin
      if (ext) begin
         ascii = 8'h00;
      end else if (letter_s && shift) begin
         ascii = base_s - ASCII_CASE_DELTA;
      end else begin
         ascii = base_s;
      end
   end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scan-code decoder. Pops bytes from the receive FIFO one at a
// time (IDLE -> POP -> PROC), folds E0/F0 prefixes into make/release events,
// suppresses typematic repeats of the held key, counts presses and provides
// an ASCII translation. All outputs are registered.
// Optional feature: define PS2_DEC_SHIFT_EN to treat 0x12/0x59 as shift
// modifiers (no events, upper-case letters while held).
module ps2_scancode_decoder
   import ps2_pkg::*;
#(
   parameter int COUNT_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [7:0]         data,
   input  logic               ready,
   input  logic               overflow,
   output logic               nextdata_n,
   output logic               key_valid,
   output logic               key_release,
   output logic               key_ext,
   output logic [7:0]         key_code,
   output logic [7:0]         key_ascii,
   output logic               key_held,
   output logic [COUNT_W-1:0] press_count,
   output logic               err
);

   localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

   ps2_state_e         state_r, state_s;
   logic [7:0]         byte_r;
   logic               load_s;
   logic               ext_p_r, ext_p_s;
   logic               brk_p_r, brk_p_s;
   logic [7:0]         held_code_r, held_code_s;
   logic               held_ext_r, held_ext_s;
   logic               key_held_r, key_held_s;
   logic [COUNT_W-1:0] count_r, count_s;
   logic               ndn_r, ndn_s;
   logic               ev_s, ev_rel_s;
   logic               proto_err_s;
   logic               err_r;
   logic               kv_r, krel_r, kext_r;
   logic [7:0]         kcode_r, kascii_r;
   logic [7:0]         ascii_s;
   logic               shift_held_s;
   logic               match_held_s;

`ifdef PS2_DEC_SHIFT_EN
   logic               shift_held_r, shift_next_s;
   assign shift_held_s = shift_held_r;
`else
   assign shift_held_s = 1'b0;
`endif

   // Translation of the byte under classification, using the current shift
   ps2_scancode_ascii u_ascii (
      .code  (byte_r),
      .ext   (ext_p_r),
      .shift (shift_held_s),
      .ascii (ascii_s)
   );

   // Byte and prefix state identify the key that is currently held down
   assign match_held_s = key_held_r && (byte_r == held_code_r) && (ext_p_r == held_ext_r);

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next-state: one byte every three cycles while the FIFO has data
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (ready) begin
               state_s = ST_POP;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_POP:  state_s = ST_PROC;
         ST_PROC: state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   // FSM outputs: pop strobe, byte classification and next decoder state
   always_comb begin
      load_s      = 1'b0;
      ndn_s       = 1'b1;
      ext_p_s     = ext_p_r;
      brk_p_s     = brk_p_r;
      ev_s        = 1'b0;
      ev_rel_s    = 1'b0;
      held_code_s = held_code_r;
      held_ext_s  = held_ext_r;
      key_held_s  = key_held_r;
      count_s     = count_r;
      proto_err_s = 1'b0;
`ifdef PS2_DEC_SHIFT_EN
      shift_next_s = shift_held_r;
`endif
      case (state_r)
         ST_IDLE: begin
            if (ready) begin
               load_s = 1'b1;
               ndn_s  = 1'b0;
            end else begin
               load_s = 1'b0;
               ndn_s  = 1'b1;
            end
         end
         ST_POP: begin
            ndn_s = 1'b1;
         end
         ST_PROC: begin
            if (byte_r == PS2_EXT_PREFIX) begin
               ext_p_s = 1'b1;
            end else if (byte_r == PS2_BRK_PREFIX) begin
               if (brk_p_r) begin
                  // F0 F0 cannot occur on a healthy link: flag and resync
                  proto_err_s = 1'b1;
                  ext_p_s     = 1'b0;
                  brk_p_s     = 1'b0;
               end else begin
                  brk_p_s = 1'b1;
               end
            end else if (is_discard(byte_r)) begin
               ext_p_s = 1'b0;
               brk_p_s = 1'b0;
`ifdef PS2_DEC_SHIFT_EN
            end else if (!ext_p_r && is_shift(byte_r)) begin
               // Shift is tracked as a modifier and never becomes the held key
               shift_next_s = ~brk_p_r;
               ext_p_s      = 1'b0;
               brk_p_s      = 1'b0;
`endif
            end else if (brk_p_r) begin
               ev_s     = 1'b1;
               ev_rel_s = 1'b1;
               ext_p_s  = 1'b0;
               brk_p_s  = 1'b0;
               if (match_held_s) begin
                  key_held_s = 1'b0;
               end else begin
                  key_held_s = key_held_r;
               end
            end else begin
               ext_p_s = 1'b0;
               brk_p_s = 1'b0;
               if (match_held_s) begin
                  // Typematic repeat of the held key: swallowed
                  ev_s = 1'b0;
               end else begin
                  ev_s        = 1'b1;
                  held_code_s = byte_r;
                  held_ext_s  = ext_p_r;
                  key_held_s  = 1'b1;
                  count_s     = count_r + COUNT_ONE;
               end
            end
         end
         default: begin
            ndn_s = 1'b1;
         end
      endcase
   end

   // Decoder state and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_r      <= 8'h00;
         ext_p_r     <= 1'b0;
         brk_p_r     <= 1'b0;
         held_code_r <= 8'h00;
         held_ext_r  <= 1'b0;
         key_held_r  <= 1'b0;
         count_r     <= {COUNT_W{1'b0}};
         ndn_r       <= 1'b1;
         err_r       <= 1'b0;
         kv_r        <= 1'b0;
         krel_r      <= 1'b0;
         kext_r      <= 1'b0;
         kcode_r     <= 8'h00;
         kascii_r    <= 8'h00;
      end else begin
         if (load_s) begin
            byte_r <= data;
         end
         ext_p_r     <= ext_p_s;
         brk_p_r     <= brk_p_s;
         held_code_r <= held_code_s;
         held_ext_r  <= held_ext_s;
         key_held_r  <= key_held_s;
         count_r     <= count_s;
         ndn_r       <= ndn_s;
         err_r       <= err_r | overflow | proto_err_s;
         kv_r        <= ev_s;
         if (ev_s) begin
            krel_r   <= ev_rel_s;
            kext_r   <= ext_p_r;
            kcode_r  <= byte_r;
            kascii_r <= ascii_s;
         end
      end
   end

`ifdef PS2_DEC_SHIFT_EN
   // Shift modifier state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_held_r <= 1'b0;
      end else begin
         shift_held_r <= shift_next_s;
      end
   end
`endif

   assign nextdata_n  = ndn_r;
   assign key_valid   = kv_r;
   assign key_release = krel_r;
   assign key_ext     = kext_r;
   assign key_code    = kcode_r;
   assign key_ascii   = kascii_r;
   assign key_held    = key_held_r;
   assign press_count = count_r;
   assign err         = err_r;

endmodule

// File: doc/ps2_scancode_decoder.md
# ps2_scancode_decoder

Consumes raw PS/2 set-2 scan-code bytes from the `ps2_keyboard` receive FIFO and pops them one at a time. It resolves E0 (extended) and F0 (break) prefixes into make/release events and tracks the currently held key. Typematic repeats are suppressed. It produces an ASCII translation and a press counter for the display/console logic downstream.

## Interface
- `COUNT_W`, 8: width of press counter
- `clk`  in  1  system clock; same domain as `ps2_keyboard`
- `rst`  in  1  reset, asynchronous, active-high
- `data`  in  8  FIFO head byte from `ps2_keyboard`
- `ready`  in  1  FIFO non-empty
- `overflow`  in  1  upstream FIFO overflow flag
- `nextdata_n`  out  1  active-low pop strobe to `ps2_keyboard`
- `key_valid`  out  1  one-cycle event pulse
- `key_release`  out  1  qualifies `key_valid`: 1 = break, 0 = make
- `key_ext`  out  1  event/held key carried E0 prefix
- `key_code`  out  8  scan code of last event
- `key_ascii`  out  8  ASCII of `key_code`; 0x00 if unmapped or extended
- `key_held`  out  1  a non-modifier key is currently down
- `press_count`  out  COUNT_W  number of distinct make events; wraps
- `err`  out  1  sticky: upstream overflow or protocol error seen

## Operation
- FSM states: IDLE, POP, PROC.
  - IDLE: if `ready`, latch `data` into `byte_r`, go to POP.
  - POP: `nextdata_n`=0 for exactly this cycle. Go to PROC.
  - PROC: upstream `ready`/`data` have now updated. Classify `byte_r`, then go to IDLE.
- Classification in PROC:
  - 0xE0: set `ext_p`.
  - 0xF0: set `brk_p`. If `brk_p` is already set, set `err`, clear both prefixes, discard.
  - 0x00, 0xAA, 0xEE, 0xFA, 0xFE, 0xFF: discard, clear both prefixes, no event.
  - Any other byte with `brk_p`=1: release event.
    - `key_valid`=1, `key_release`=1, `key_code`=byte, `key_ext`=`ext_p`.
    - If byte and `ext_p` match the held key, `key_held`←0.
    - A release of a non-held key still pulses; `key_held` is unchanged.
  - Any other byte with `brk_p`=0:
    - If `key_held` and byte/`ext_p` equal the held key: typematic repeat, no pulse, no count.
    - Otherwise make event: `key_valid`=1, `key_release`=0, held key←byte/`ext_p`, `key_held`←1, `press_count`+1 modulo 2^COUNT_W.
  - Prefixes clear after every non-prefix byte.
- `err` sets when `overflow`=1 in any cycle, and on a double F0. It clears only on `rst`.
- `key_code`/`key_ext`/`key_ascii` hold their values between events.

## Timing
- Reset values:
  - `nextdata_n`=1
  - `key_valid`=0, `key_release`=0, `key_ext`=0
  - `key_code`=0x00, `key_ascii`=0x00
  - `key_held`=0, `press_count`=0, `err`=0
  - FSM in IDLE, prefixes cleared.
- All outputs are registered. `nextdata_n` is never low for two consecutive cycles.
- Latency: `ready` seen in IDLE at cycle N → pop at N+1 → `key_valid` high in N+3 (registered from PROC at N+2).
- Throughput: 3 cycles per byte. A back-to-back FIFO drains without idle cycles.
- `ready` falling in POP/PROC is legal and expected. IDLE re-samples it.
- Async `rst` mid-POP drives `nextdata_n` high immediately. A partially decoded prefix sequence is lost.

## Configuration
- `PS2_DEC_SHIFT_EN`:
  - Defined: 0x12/0x59 make/break set/clear internal `shift_held`. They produce no event, no count, and do not affect `key_held`. While `shift_held`=1, letter codes map to upper case (0x41–0x5A).
  - Undefined: shift codes are ordinary keys with ASCII 0x00, and letters are always lower case.

## Structure
- Package `ps2_pkg`: FSM state enum; prefix constants (0xE0, 0xF0); discard-code list; shift codes.
- Sub-module `ps2_scancode_ascii`: combinational set-2 → ASCII ROM. Inputs are code, ext and shift; output is ascii.
  - Covers a–z, 0–9, space 0x29→0x20, enter 0x5A→0x0D.
  - Everything else maps to 0x00, and ext=1 always maps to 0x00.

## Test plan
- Bytes 1C, F0, 1C: make event code 0x1C, ascii 0x61, `press_count`=1; then release pulse, `key_held`=0.
- Bytes 1C×5 (typematic), then F0 1C: exactly one make pulse, count=1, one release pulse.
- Bytes E0 75, E0 F0 75: make with `key_ext`=1, ascii 0x00; release with `key_ext`=1; count=1.
- 256 distinct make/break pairs with COUNT_W=8: `press_count` wraps to 0x00.
- AA, F0 F0 1C, upstream `overflow` pulse: no event for AA, `err`=1, stays 1 until `rst`.
- With `PS2_DEC_SHIFT_EN`, bytes 12 1C F0 1C F0 12: event ascii 0x41, count=1, no event for shift. Assert `rst` during POP → `nextdata_n`=1 same cycle.
